// File: rtl/md_issue_ctrl_if.sv
// E-stage request and MD-unit strobe bundle.
// The controller takes the slave side; the E stage drives the master side.
interface md_issue_ctrl_if #(
    parameter int OP_W = 3
);
    logic            e_md_req;
    logic [OP_W-1:0] e_md_op;
    logic            e_hi_wr;
    logic            e_lo_wr;
    logic            md_start;
    logic [OP_W-1:0] md_op;
    logic            md_hi_write;
    logic            md_lo_write;

    modport master (
        output e_md_req, e_md_op, e_hi_wr, e_lo_wr,
        input  md_start, md_op, md_hi_write, md_lo_write
    );

    modport slave (
        input  e_md_req, e_md_op, e_hi_wr, e_lo_wr,
        output md_start, md_op, md_hi_write, md_lo_write
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue and hazard controller.
// Counts operation latency, stalls D on HI/LO use, flags bad issue.
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int OP_W     = 3
) (
    input  logic            clk,
    input  logic            reset,
    md_issue_ctrl_if.slave  md,
    input  logic            d_md_use,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [OP_W-1:0] cur_op,
    output logic            err
);
    localparam int CW = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            done_n;
    logic [OP_W-1:0] cur_op_n;
    logic            err_n;
    logic            valid_op;
    logic            is_div;
    logic            issue;
    logic            multi_req;
    logic            bad;

    assign busy = (state == RUN);

    // Issue decode and MD-unit strobes; HI wins over LO.
    always_comb begin
        valid_op       = (md.e_md_op <= OP_W'(4));
        is_div         = (md.e_md_op == OP_W'(2)) ||
                         (md.e_md_op == OP_W'(3));
        issue          = md.e_md_req & ~busy & valid_op;
        md.md_start    = issue;
        md.md_op       = md.e_md_op;
        md.md_hi_write = md.e_hi_wr & ~busy & ~md.e_md_req;
        md.md_lo_write = md.e_lo_wr & ~busy & ~md.e_md_req &
                         ~md.e_hi_wr;
        stall          = d_md_use & (busy | md.e_md_req |
                                     md.e_hi_wr | md.e_lo_wr);
    end

    // Illegal issue detection, sticky until reset.
    always_comb begin
        multi_req = (md.e_md_req & md.e_hi_wr) |
                    (md.e_md_req & md.e_lo_wr) |
                    (md.e_hi_wr  & md.e_lo_wr);
        bad       = (md.e_md_req & busy) |
                    (md.e_md_req & ~valid_op) |
                    ((md.e_hi_wr | md.e_lo_wr) & busy) |
                    multi_req;
        err_n     = err | bad;
    end

    // Next state: load latency on issue, count down while running.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        done_n   = 1'b0;
        cur_op_n = cur_op;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    cnt_n    = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                    cur_op_n = md.e_md_op;
                    state_n  = RUN;
                end
            end
            RUN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            cur_op <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            done   <= done_n;
            cur_op <= cur_op_n;
            err    <= err_n;
        end
    end
endmodule
